flash_word_fetch: RTL and testbench
===================================

Name: flash_word_fetch

Overview:
- Producer end of the finish/readdata handshake used by the audio sample sender.
- Reads 32-bit words from the flash Avalon-MM slave, one word at a time.
- For each word: presents it on readdata, pulses finish, then waits for the consumer's word_done before fetching the next word.
- Owns the playback word address: direction, restart and wrap-around.

Parameters:
ADDR_W, 23, flash word-address width
START_ADDR, 23'h000000, first word of the audio region
END_ADDR, 23'h07FFFF, last word of the audio region (inclusive); must be >= START_ADDR

Ports:
CLK_50M  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
play  input  1  level; 1 = fetching enabled, 0 = pause after the current word
direction  input  1  1 = forward (address +1), 0 = backward (address -1)
restart  input  1  single-cycle pulse; reposition to START_ADDR (forward) or END_ADDR (backward)
word_done  input  1  single-cycle pulse from consumer; both samples of the current word played
flash_mem_address  output  ADDR_W  Avalon word address
flash_mem_read  output  1  Avalon read request
flash_mem_byteenable  output  4  constant 4'hF
flash_mem_waitrequest  input  1  Avalon waitrequest
flash_mem_readdata  input  32  Avalon read data
flash_mem_readdatavalid  input  1  Avalon read data valid
readdata  output  32  latched flash word for the consumer
finish  output  1  one-cycle pulse; readdata holds a new word
cur_addr  output  ADDR_W  current word address (status/debug)

Behaviour:
- Reset (async, active-high): state IDLE; cur_addr = START_ADDR; flash_mem_read = 0; finish = 0; readdata = 0; restart_pending = 0.
- flash_mem_address equals cur_addr at all times.
- States:
  - IDLE: when play = 1, go to ISSUE.
  - ISSUE: flash_mem_read = 1. Stay while flash_mem_waitrequest = 1. When waitrequest = 0, go to WAIT_VALID; read deasserts the next cycle.
  - WAIT_VALID: read = 0. On readdatavalid = 1, latch flash_mem_readdata into readdata and go to DONE.
  - DONE: finish = 1 for exactly this one cycle, then update cur_addr (see address rules) and go to WAIT_CONSUME.
  - WAIT_CONSUME: on word_done, go to ISSUE if play = 1, else IDLE. Without word_done, stay.
- Latency: finish is high on the cycle after readdatavalid is sampled.
- readdata stability: readdata changes only on a readdatavalid capture in WAIT_VALID; it is stable from finish until the next capture.
- readdatavalid outside WAIT_VALID is ignored. No second outstanding read is ever issued.
- Address rules, applied in DONE:
  - Forward: END_ADDR wraps to START_ADDR; otherwise +1.
  - Backward: START_ADDR wraps to END_ADDR; otherwise -1.
  - direction is sampled in DONE only.
- Restart:
  - In IDLE or WAIT_CONSUME: cur_addr loads START_ADDR (direction = 1) or END_ADDR (direction = 0) on the next edge.
  - In ISSUE or WAIT_VALID: sets restart_pending. The in-flight read completes at the old address. In DONE the restart value replaces the increment, and restart_pending clears.
  - In DONE: treated as pending; the restart value wins over the increment.
- Simultaneous restart and word_done in WAIT_CONSUME: the address reloads and the state moves to ISSUE in the same edge; the next read uses the restart address.
- Pause: play is checked only in IDLE and WAIT_CONSUME. An in-flight read always completes and pulses finish.
- Reset mid-transaction: read drops immediately; any later readdatavalid lands in IDLE and is ignored.

Test Plan:
- Basic forward fetch: reset, play = 1, direction = 1, waitrequest = 0, readdatavalid 2 cycles after read with data 32'hA1B2C3D4 -> address 0 read once; finish pulses 1 cycle with readdata = 32'hA1B2C3D4; cur_addr = 1; no read until word_done; after word_done, a read at address 1.
- Waitrequest stall: waitrequest held high 5 cycles -> read stays high at a constant address for 6 cycles; exactly one readdatavalid is accepted; a spurious readdatavalid in WAIT_CONSUME leaves readdata unchanged.
- Wrap: force cur_addr = END_ADDR forward -> next cur_addr = START_ADDR. Backward from START_ADDR -> 23'h07FFFF.
- Restart mid-read: restart pulsed in WAIT_VALID at address 0x100, direction = 0 -> word from 0x100 delivered with finish; cur_addr becomes 0x07FFFF, not 0x0FF.
- Pause and simultaneous events: play = 0 before word_done -> IDLE with no read. play = 1 -> resumes at the next address. word_done plus restart (forward) in the same cycle -> next read at START_ADDR.
- Async reset asserted during ISSUE -> read, finish and readdata go to 0 immediately; cur_addr = START_ADDR.

Source files
------------

// File: rtl/flash_word_fetch.sv
// flash_word_fetch: fetches one 32-bit word at a time from the flash Avalon-MM
// slave, hands it to the audio sample sender through the finish/word_done
// handshake, and owns the playback word address (direction, restart, wrap).
`timescale 1ns/1ps

module flash_word_fetch #(
    parameter int unsigned        ADDR_W     = 23,
    parameter logic [ADDR_W-1:0]  START_ADDR = 23'h000000,
    parameter logic [ADDR_W-1:0]  END_ADDR   = 23'h07FFFF
) (
    input  logic              CLK_50M,
    input  logic              reset,
    input  logic              play,
    input  logic              direction,
    input  logic              restart,
    input  logic              word_done,
    output logic [ADDR_W-1:0] flash_mem_address,
    output logic              flash_mem_read,
    output logic [3:0]        flash_mem_byteenable,
    input  logic              flash_mem_waitrequest,
    input  logic [31:0]       flash_mem_readdata,
    input  logic              flash_mem_readdatavalid,
    output logic [31:0]       readdata,
    output logic              finish,
    output logic [ADDR_W-1:0] cur_addr
);

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        ISSUE        = 3'd1,
        WAIT_VALID   = 3'd2,
        DONE         = 3'd3,
        WAIT_CONSUME = 3'd4
    } state_t;

    state_t            state;
    logic              restart_pending;
    logic [ADDR_W-1:0] restart_addr;
    logic [ADDR_W-1:0] next_addr;

    // Next word address in the playback direction, wrapping at the region ends.
    function automatic logic [ADDR_W-1:0] step_addr(input logic [ADDR_W-1:0] a,
                                                    input logic              fwd);
        if (fwd) begin
            return (a == END_ADDR) ? START_ADDR : ADDR_W'(a + 1'b1);
        end
        return (a == START_ADDR) ? END_ADDR : ADDR_W'(a - 1'b1);
    endfunction

    // A restart repositions to the region start when playing forward, the end otherwise.
    assign restart_addr = direction ? START_ADDR : END_ADDR;
    assign next_addr    = step_addr(cur_addr, direction);

    // The read address is always the current playback address; full-word reads only.
    assign flash_mem_address    = cur_addr;
    assign flash_mem_byteenable = 4'hF;

    // Fetch sequencer: one outstanding read, word handed over with a finish pulse.
    always_ff @(posedge CLK_50M or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            cur_addr        <= START_ADDR;
            flash_mem_read  <= 1'b0;
            finish          <= 1'b0;
            readdata        <= 32'h0;
            restart_pending <= 1'b0;
        end else begin
            finish <= 1'b0;
            case (state)
                IDLE: begin
                    if (restart) begin
                        cur_addr <= restart_addr;
                    end
                    if (play) begin
                        state          <= ISSUE;
                        flash_mem_read <= 1'b1;
                    end
                end
                ISSUE: begin
                    // Restart cannot move the address under an in-flight read; defer it.
                    if (restart) begin
                        restart_pending <= 1'b1;
                    end
                    if (!flash_mem_waitrequest) begin
                        state          <= WAIT_VALID;
                        flash_mem_read <= 1'b0;
                    end
                end
                WAIT_VALID: begin
                    if (restart) begin
                        restart_pending <= 1'b1;
                    end
                    if (flash_mem_readdatavalid) begin
                        readdata <= flash_mem_readdata;
                        finish   <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    // A deferred or coincident restart takes precedence over stepping.
                    if (restart || restart_pending) begin
                        cur_addr <= restart_addr;
                    end else begin
                        cur_addr <= next_addr;
                    end
                    restart_pending <= 1'b0;
                    state           <= WAIT_CONSUME;
                end
                WAIT_CONSUME: begin
                    if (restart) begin
                        cur_addr <= restart_addr;
                    end
                    if (word_done) begin
                        if (play) begin
                            state          <= ISSUE;
                            flash_mem_read <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state          <= IDLE;
                    flash_mem_read <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flash_word_fetch.sv
// Bench for flash_word_fetch: Avalon flash slave model, a table of hand-derived
// word transactions, directed corner cases and a randomized run checked against
// a transaction-level playback-address model.
`timescale 1ns/1ps

module tb_flash_word_fetch;

    localparam logic [22:0] START = 23'h000000;
    localparam logic [22:0] END   = 23'h07FFFF;

    logic        clk;
    logic        rst;
    logic        play;
    logic        direction;
    logic        restart;
    logic        word_done;
    logic [22:0] flash_mem_address;
    logic        flash_mem_read;
    logic [3:0]  flash_mem_byteenable;
    logic        flash_mem_waitrequest;
    logic [31:0] flash_mem_readdata;
    logic        flash_mem_readdatavalid;
    logic [31:0] readdata;
    logic        finish;
    logic [22:0] cur_addr;

    flash_word_fetch dut (
        .CLK_50M                 (clk),
        .reset                   (rst),
        .play                    (play),
        .direction               (direction),
        .restart                 (restart),
        .word_done               (word_done),
        .flash_mem_address       (flash_mem_address),
        .flash_mem_read          (flash_mem_read),
        .flash_mem_byteenable    (flash_mem_byteenable),
        .flash_mem_waitrequest   (flash_mem_waitrequest),
        .flash_mem_readdata      (flash_mem_readdata),
        .flash_mem_readdatavalid (flash_mem_readdatavalid),
        .readdata                (readdata),
        .finish                  (finish),
        .cur_addr                (cur_addr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    // Slave model state and statistics
    int          slv_stall = 0;
    int          slv_lat   = 1;
    int          rd_count  = 0;
    logic [22:0] rd_addr   = '0;
    logic [22:0] slv_a     = '0;
    int          stall_err = 0;
    int          spur_req  = 0;
    int          spur_done = 0;

    // Cycle monitors
    int read_hi = 0;
    int fin_cnt = 0;

    // Reference model state
    logic [22:0] m_addr    = '0;
    logic [31:0] last_word = '0;
    logic        primed    = 1'b0;

    typedef struct {
        logic        dir;
        int          rmode;
        int          stall;
        int          lat;
        logic [22:0] exp_rd;
        logic [22:0] exp_next;
    } vec_t;

    vec_t vecs [11];

    function automatic logic [31:0] mem_word(input logic [22:0] a);
        if (a == 23'h0) return 32'hA1B2C3D4;
        return 32'h5A000000 ^ {9'h0, a} ^ {a[7:0], 24'h0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Count cycles with read / finish high, sampled at the edge that closes the cycle.
    always @(posedge clk) begin
        if (flash_mem_read) read_hi++;
        if (finish)         fin_cnt++;
    end

    // Avalon flash slave: optional waitrequest stall, fixed read latency, spurious valids on request.
    initial begin
        flash_mem_waitrequest   = 1'b0;
        flash_mem_readdatavalid = 1'b0;
        flash_mem_readdata      = 32'h0;
        forever begin
            @(negedge clk);
            if (spur_req != spur_done) begin
                flash_mem_readdatavalid = 1'b1;
                flash_mem_readdata      = 32'hDEADBEEF;
                spur_done++;
                @(negedge clk);
                flash_mem_readdatavalid = 1'b0;
                flash_mem_readdata      = 32'h0BAD0BAD;
            end else if (flash_mem_read) begin
                slv_a = flash_mem_address;
                if (slv_stall > 0) begin
                    flash_mem_waitrequest = 1'b1;
                    for (int i = 0; i < slv_stall; i++) begin
                        @(negedge clk);
                        if (flash_mem_read && flash_mem_address != slv_a) stall_err++;
                    end
                    flash_mem_waitrequest = 1'b0;
                end
                rd_count++;
                rd_addr = slv_a;
                for (int i = 0; i < slv_lat; i++) @(negedge clk);
                flash_mem_readdatavalid = 1'b1;
                flash_mem_readdata      = mem_word(slv_a);
                @(negedge clk);
                flash_mem_readdatavalid = 1'b0;
                flash_mem_readdata      = 32'h0BAD0BAD;
            end
        end
    end

    // One word transaction. rmode: 0 none, 1 restart with word_done/play,
    // 2 restart during ISSUE, 3 restart during WAIT_VALID, 4 restart in the finish cycle.
    task automatic run_word(input logic dir, input int rmode, input int stall, input int lat,
                            input logic [22:0] exp_rd, input logic [22:0] exp_next);
        int   base_rd;
        int   base_hi;
        int   cyc;
        logic fired;
        logic saw_read;
        slv_stall = stall;
        slv_lat   = lat;
        direction = dir;
        base_rd   = rd_count;
        base_hi   = read_hi;
        play      = 1'b1;
        word_done = primed;
        restart   = (rmode == 1);
        @(negedge clk);
        word_done = 1'b0;
        restart   = 1'b0;
        cyc       = 0;
        fired     = 1'b0;
        saw_read  = 1'b0;
        while (!finish && cyc < 200) begin
            if (fired) begin
                restart = 1'b0;
            end else if ((rmode == 2 && flash_mem_read) ||
                         (rmode == 3 && saw_read && !flash_mem_read)) begin
                restart = 1'b1;
                fired   = 1'b1;
            end
            if (flash_mem_read) saw_read = 1'b1;
            @(negedge clk);
            cyc++;
        end
        restart = 1'b0;
        check("finish_seen", 32'(finish), 32'd1);
        check("read_count", 32'(rd_count - base_rd), 32'd1);
        check("read_addr", 32'(rd_addr), 32'(exp_rd));
        check("read_hi_cycles", 32'(read_hi - base_hi), 32'(stall + 1));
        check("readdata", readdata, mem_word(exp_rd));
        if (rmode == 4) restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        check("finish_width", 32'(finish), 32'd0);
        check("cur_addr", 32'(cur_addr), 32'(exp_next));
        check("flash_addr", 32'(flash_mem_address), 32'(exp_next));
        check("read_idle", 32'(flash_mem_read), 32'd0);
        last_word = mem_word(exp_rd);
        primed    = 1'b1;
    endtask

    // Transaction-level model: which address is read and where playback goes next.
    task automatic model_word(input logic dir, input int rmode, input int stall, input int lat);
        logic [22:0] tgt;
        logic [22:0] rd;
        logic [22:0] nx;
        tgt = dir ? START : END;
        rd  = (rmode == 1) ? tgt : m_addr;
        if (rmode >= 2)  nx = tgt;
        else if (dir)    nx = (rd == END)   ? START : 23'(rd + 23'd1);
        else             nx = (rd == START) ? END   : 23'(rd - 23'd1);
        run_word(dir, rmode, stall, lat, rd, nx);
        m_addr = nx;
    endtask

    // Release the current word with play low: the fetcher must park without reading.
    task automatic pause_word();
        int base_hi;
        base_hi   = read_hi;
        play      = 1'b0;
        word_done = 1'b1;
        @(negedge clk);
        word_done = 1'b0;
        repeat (4) @(negedge clk);
        check("pause_no_read", 32'(read_hi - base_hi), 32'd0);
        check("pause_addr", 32'(cur_addr), 32'(m_addr));
        primed = 1'b0;
    endtask

    initial begin
        int base;
        int base_fin;
        logic dir;
        int rmode;

        vecs[0]  = '{1'b1, 0, 0, 1, 23'h000000, 23'h000001};
        vecs[1]  = '{1'b1, 0, 5, 2, 23'h000001, 23'h000002};
        vecs[2]  = '{1'b0, 0, 0, 1, 23'h000002, 23'h000001};
        vecs[3]  = '{1'b0, 0, 1, 1, 23'h000001, 23'h000000};
        vecs[4]  = '{1'b0, 0, 0, 3, 23'h000000, 23'h07FFFF};
        vecs[5]  = '{1'b1, 0, 0, 1, 23'h07FFFF, 23'h000000};
        vecs[6]  = '{1'b0, 1, 0, 1, 23'h07FFFF, 23'h07FFFE};
        vecs[7]  = '{1'b1, 1, 2, 1, 23'h000000, 23'h000001};
        vecs[8]  = '{1'b1, 4, 0, 1, 23'h000001, 23'h000000};
        vecs[9]  = '{1'b0, 2, 3, 1, 23'h000000, 23'h07FFFF};
        vecs[10] = '{1'b1, 3, 0, 2, 23'h07FFFF, 23'h000000};

        rst       = 1'b1;
        play      = 1'b0;
        direction = 1'b1;
        restart   = 1'b0;
        word_done = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cur_addr", 32'(cur_addr), 32'(START));
        check("rst_read", 32'(flash_mem_read), 32'd0);
        check("rst_finish", 32'(finish), 32'd0);
        check("rst_readdata", readdata, 32'h0);
        check("byteenable", 32'(flash_mem_byteenable), 32'hF);
        rst = 1'b0;
        @(negedge clk);
        check("idle_no_read", 32'(flash_mem_read), 32'd0);

        // Table of hand-derived transactions: basic, stall, both wraps, all restart points.
        for (int i = 0; i < 11; i++) begin
            run_word(vecs[i].dir, vecs[i].rmode, vecs[i].stall, vecs[i].lat,
                     vecs[i].exp_rd, vecs[i].exp_next);
            if (i == 0) begin
                base = read_hi;
                repeat (3) @(negedge clk);
                check("hold_until_word_done", 32'(read_hi - base), 32'd0);
            end
        end
        m_addr = vecs[10].exp_next;

        // Spurious readdatavalid while waiting for the consumer must be ignored.
        base     = read_hi;
        base_fin = fin_cnt;
        spur_req++;
        repeat (4) @(negedge clk);
        check("spurious_readdata", readdata, last_word);
        check("spurious_finish", 32'(fin_cnt - base_fin), 32'd0);
        check("spurious_no_read", 32'(read_hi - base), 32'd0);

        // Walk forward to 0x100, then restart backward during the read of 0x100.
        for (int i = 0; i < 256; i++) model_word(1'b1, 0, 0, 1);
        check("walk_addr", 32'(m_addr), 32'h100);
        run_word(1'b0, 3, 0, 1, 23'h000100, 23'h07FFFF);
        m_addr = 23'h07FFFF;

        // Pause, resume at the next address, then word_done together with a forward restart.
        pause_word();
        model_word(1'b1, 0, 0, 1);
        model_word(1'b0, 0, 0, 1);
        run_word(1'b1, 1, 0, 1, 23'h000000, 23'h000001);
        m_addr = 23'h000001;

        // Randomized traffic against the model.
        for (int i = 0; i < 150; i++) begin
            dir   = 1'($urandom_range(0, 1));
            rmode = int'($urandom_range(0, 4));
            if (primed && $urandom_range(0, 9) == 0) pause_word();
            model_word(dir, rmode, int'($urandom_range(0, 3)), int'($urandom_range(1, 3)));
        end

        // Asynchronous reset while a read is stalled in ISSUE.
        slv_stall = 4;
        slv_lat   = 2;
        play      = 1'b1;
        word_done = 1'b1;
        @(negedge clk);
        word_done = 1'b0;
        play      = 1'b0;
        check("pre_reset_read", 32'(flash_mem_read), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_read", 32'(flash_mem_read), 32'd0);
        check("arst_finish", 32'(finish), 32'd0);
        check("arst_readdata", readdata, 32'h0);
        check("arst_cur_addr", 32'(cur_addr), 32'(START));
        @(negedge clk);
        rst      = 1'b0;
        base_fin = fin_cnt;
        repeat (12) @(negedge clk);
        check("late_valid_readdata", readdata, 32'h0);
        check("late_valid_finish", 32'(fin_cnt - base_fin), 32'd0);
        check("post_reset_idle", 32'(flash_mem_read), 32'd0);
        primed = 1'b0;
        m_addr = START;
        model_word(1'b1, 0, 0, 1);

        check("stall_addr_hold", 32'(stall_err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
